// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver: blank pattern,
// hex decode table (g..a, active low) and a width helper.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Minimum of one bit so a counter never collapses to zero width.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((32'sd1 <<< width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_hex_seg_lut.sv
// Combinational hex nibble to active-low seven-segment pattern (g..a).
module hex_seg_lut
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg_n
);

    // Table lookup; every nibble value has an entry.
    always_comb begin
        o_seg_n = HEX_SEG_TABLE[i_nibble];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Scans an N-digit common-anode display one digit at a time from shadowed
// hex data, with decimal points, leading-zero blanking and per-digit blink.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_LOG2 = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    input  logic                    blank_lz,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_tick
);

    localparam int IDX_W = clog2(NUM_DIGITS);
    localparam int PRE_W = clog2(SCAN_DIV);

    logic [PRE_W-1:0]          r_presc;
    logic [IDX_W-1:0]          r_idx;
    logic [4*NUM_DIGITS-1:0]   r_sh_value;
    logic [NUM_DIGITS-1:0]     r_sh_dp;
    logic [NUM_DIGITS-1:0]     r_sh_blink;
    logic [BLINK_LOG2-1:0]     r_frame_cnt;
    logic                      r_blink_phase;
    logic                      r_wrap_d;

    logic                      w_presc_last;
    logic                      w_idx_last;
    logic                      w_wrap;
    logic [3:0]                w_nibble;
    logic [6:0]                w_dec_seg_n;
    logic [NUM_DIGITS-1:0]     w_hi_zero;
    logic                      w_lz_blank;
    logic                      w_blink;
    logic                      w_sel_dp;
    logic [NUM_DIGITS-1:0]     w_an_n;

    assign w_presc_last = (r_presc == PRE_W'(SCAN_DIV - 1));
    assign w_idx_last   = (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_wrap       = w_presc_last & w_idx_last;
    assign w_nibble     = r_sh_value[{r_idx, 2'b00} +: 4];
    assign w_sel_dp     = r_sh_dp[r_idx];
    assign w_blink      = r_sh_blink[r_idx] & r_blink_phase;
    assign w_lz_blank   = blank_lz & (r_idx != '0) & w_hi_zero[r_idx];
    assign w_an_n       = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx);

    // Bit i set when nibble i and every more significant nibble are zero.
    always_comb begin
        w_hi_zero = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_hi_zero[i] = ~|(r_sh_value >> (4 * i));
        end
    end

    hex_seg_lut u_lut (
        .i_nibble (w_nibble),
        .o_seg_n  (w_dec_seg_n)
    );

    // Shadow capture, scan counters, blink phase and registered pin drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc       <= '0;
            r_idx         <= '0;
            r_sh_value    <= '0;
            r_sh_dp       <= '0;
            r_sh_blink    <= '0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_wrap_d      <= 1'b0;
            seg_n         <= SEG_BLANK;
            dp_n          <= 1'b1;
            an_n          <= '1;
            frame_tick    <= 1'b0;
        end else begin
            if (load) begin
                r_sh_value <= value;
                r_sh_dp    <= dp_in;
                r_sh_blink <= blink_en;
            end else begin
                r_sh_value <= r_sh_value;
                r_sh_dp    <= r_sh_dp;
                r_sh_blink <= r_sh_blink;
            end

            if (w_presc_last) begin
                r_presc <= '0;
                r_idx   <= w_idx_last ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_presc <= r_presc + PRE_W'(1);
                r_idx   <= r_idx;
            end

            if (w_wrap) begin
                r_frame_cnt   <= r_frame_cnt + BLINK_LOG2'(1);
                r_blink_phase <= r_blink_phase ^ (&r_frame_cnt);
            end else begin
                r_frame_cnt   <= r_frame_cnt;
                r_blink_phase <= r_blink_phase;
            end

            // Delayed so the pulse lines up with digit 0 appearing on the pins.
            r_wrap_d   <= w_wrap;
            frame_tick <= r_wrap_d;
            an_n       <= w_an_n;

            if (w_blink) begin
                seg_n <= SEG_BLANK;
                dp_n  <= 1'b1;
            end else if (w_lz_blank) begin
                seg_n <= SEG_BLANK;
                dp_n  <= ~w_sel_dp;
            end else begin
                seg_n <= w_dec_seg_n;
                dp_n  <= ~w_sel_dp;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench: directed phases plus random traffic, compared against a
// time-indexed reference model of the scanned display.
module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int SCAN  = 4;
    localparam int BLOG2 = 1;
    localparam int FRAME = SCAN * N;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  value;
    logic         load;
    logic [3:0]   dp_in;
    logic [3:0]   blink_en;
    logic         blank_lz;
    logic [6:0]   seg_n;
    logic         dp_n;
    logic [3:0]   an_n;
    logic         frame_tick;

    int vectors = 0;
    int miscompares = 0;

    // Reference state: non-reset edges since reset, and the shadowed data.
    int          m_t;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic [3:0]  m_blink;

    logic [6:0] ref_lut [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg7_scan_driver #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (SCAN),
        .BLINK_LOG2 (BLOG2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .load       (load),
        .dp_in      (dp_in),
        .blink_en   (blink_en),
        .blank_lz   (blank_lz),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic step(input string tag);
        logic [6:0] e_seg;
        logic       e_dp;
        logic [3:0] e_an;
        logic       e_ft;
        logic       was_rst;
        int         d;
        int         frames;
        logic       phase;
        logic       lz;
        was_rst = rst;
        if (rst) begin
            e_seg = 7'h7F;
            e_dp  = 1'b1;
            e_an  = 4'hF;
            e_ft  = 1'b0;
        end else begin
            d      = (m_t % FRAME) / SCAN;
            frames = m_t / FRAME;
            phase  = ((frames >> BLOG2) % 2) == 1;
            lz     = blank_lz && (d > 0) && ((m_val >> (4 * d)) == 16'h0);
            e_an   = ~(4'b0001 << d);
            e_ft   = (m_t > 0) && ((m_t % FRAME) == 0);
            if (m_blink[d] && phase) begin
                e_seg = 7'h7F;
                e_dp  = 1'b1;
            end else if (lz) begin
                e_seg = 7'h7F;
                e_dp  = ~m_dp[d];
            end else begin
                e_seg = ref_lut[(m_val >> (4 * d)) & 16'hF];
                e_dp  = ~m_dp[d];
            end
        end

        @(posedge clk);
        if (was_rst) begin
            m_t     = 0;
            m_val   = 16'h0;
            m_dp    = 4'h0;
            m_blink = 4'h0;
        end else begin
            m_t = m_t + 1;
            if (load) begin
                m_val   = value;
                m_dp    = dp_in;
                m_blink = blink_en;
            end
        end
        #1;

        vectors++;
        assert (seg_n === e_seg) else begin
            miscompares++;
            $error("FAIL %s seg_n got %b exp %b", tag, seg_n, e_seg);
        end
        vectors++;
        assert (dp_n === e_dp) else begin
            miscompares++;
            $error("FAIL %s dp_n got %b exp %b", tag, dp_n, e_dp);
        end
        vectors++;
        assert (an_n === e_an) else begin
            miscompares++;
            $error("FAIL %s an_n got %h exp %h", tag, an_n, e_an);
        end
        vectors++;
        assert (frame_tick === e_ft) else begin
            miscompares++;
            $error("FAIL %s frame_tick got %b exp %b", tag, frame_tick, e_ft);
        end
        if (!was_rst) begin
            vectors++;
            assert ($countones(~an_n) == 1) else begin
                miscompares++;
                $error("FAIL %s one_cold an_n got %b exp one zero bit", tag, an_n);
            end
        end
    endtask

    task automatic run(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            step(tag);
        end
    endtask

    initial begin
        m_t = 0; m_val = 16'h0; m_dp = 4'h0; m_blink = 4'h0;
        rst = 1'b1; value = 16'h0; load = 1'b0; dp_in = 4'h0;
        blink_en = 4'h0; blank_lz = 1'b0;
        run(2, "reset");

        rst = 1'b0;
        run(10, "scan");
        rst = 1'b1;
        run(3, "reset_mid");
        rst = 1'b0;
        run(40, "scan_resume");

        value = 16'h1A3F; dp_in = 4'b0100; load = 1'b1;
        step("decode_load");
        load = 1'b0;
        run(20, "decode");

        value = 16'h0005; dp_in = 4'b0000; blank_lz = 1'b1; load = 1'b1;
        step("lz5_load");
        load = 1'b0;
        run(20, "lz5");
        value = 16'h0000; load = 1'b1;
        step("lz0_load");
        load = 1'b0;
        run(20, "lz0");

        blank_lz = 1'b0; value = 16'h8888; blink_en = 4'b0001; load = 1'b1;
        step("blink_load");
        load = 1'b0;
        run(100, "blink");

        blink_en = 4'h0; value = 16'h1111; load = 1'b1;
        step("shadow_a");
        load = 1'b0;
        run(2, "shadow_a");
        value = 16'h2222; load = 1'b1;
        step("shadow_b");
        load = 1'b0;
        run(20, "shadow_b");

        for (int i = 0; i < 1000; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            load     = ($urandom_range(0, 3) == 0);
            value    = 16'($urandom);
            dp_in    = 4'($urandom);
            blink_en = 4'($urandom);
            blank_lz = 1'($urandom);
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
